// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for the oc8051 ALU, holding operands for multi-cycle ops
package alu_arbiter_pkg;
   typedef enum logic [3:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DA, OP_NOT, OP_AND,
      OP_XOR, OP_OR, OP_RL, OP_RLC, OP_RR, OP_RRC, OP_PCS, OP_XCH
   } opcode_e;
endpackage

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  opcode_e    req0_op,
   input  logic [7:0] req0_src1,
   input  logic [7:0] req0_src2,
   input  logic [7:0] req0_src3,
   input  logic [2:0] req0_flags,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  opcode_e    req1_op,
   input  logic [7:0] req1_src1,
   input  logic [7:0] req1_src2,
   input  logic [7:0] req1_src3,
   input  logic [2:0] req1_flags,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_des1,
   output logic [7:0] rsp_des2,
   output logic [7:0] rsp_des_acc,
   output logic [2:0] rsp_flags,
   output opcode_e    alu_op,
   output logic [7:0] alu_src1,
   output logic [7:0] alu_src2,
   output logic [7:0] alu_src3,
   output logic       alu_srcCy,
   output logic       alu_srcAc,
   output logic       alu_bit_in,
   input  logic [7:0] alu_des1,
   input  logic [7:0] alu_des2,
   input  logic [7:0] alu_des_acc,
   input  logic       alu_desCy,
   input  logic       alu_desAc,
   input  logic       alu_desOv,
   output logic       busy
);
   localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
   state_e state, state_nxt;
   logic last_grant, grant, accept;
   logic [CW-1:0] cnt;
   opcode_e op, in_op;
   logic [7:0] src1, src2, src3, in_src1, in_src2, in_src3;
   logic [2:0] flags, in_flags;
   assign grant = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = state == IDLE && !grant;
   assign req1_ready = state == IDLE && grant;
   assign accept = state == IDLE && (req0_valid || req1_valid);
   assign in_op = grant ? req1_op : req0_op;
   assign in_src1 = grant ? req1_src1 : req0_src1;
   assign in_src2 = grant ? req1_src2 : req0_src2;
   assign in_src3 = grant ? req1_src3 : req0_src3;
   assign in_flags = grant ? req1_flags : req0_flags;
   // state register; reset drops any op in flight
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   // capture the granted op, count down its hold time and sample the ALU on the last cycle
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         op <= OP_NOP;
         src1 <= '0;
         src2 <= '0;
         src3 <= '0;
         flags <= '0;
         cnt <= '0;
         last_grant <= 1'b1;
         rsp_id <= 1'b0;
         rsp_des1 <= '0;
         rsp_des2 <= '0;
         rsp_des_acc <= '0;
         rsp_flags <= '0;
      end else begin
         if (accept) begin
            op <= in_op;
            src1 <= in_src1;
            src2 <= in_src2;
            src3 <= in_src3;
            flags <= in_flags;
            rsp_id <= grant;
            last_grant <= grant;
            cnt <= in_op == OP_MUL ? CW'(MUL_CYCLES - 1) : in_op == OP_DIV ? CW'(DIV_CYCLES - 1) : '0;
         end else if (state == EXEC && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == EXEC && cnt == '0) begin
            rsp_des1 <= alu_des1;
            rsp_des2 <= alu_des2;
            rsp_des_acc <= alu_des_acc;
            rsp_flags <= {alu_desOv, alu_desAc, alu_desCy};
         end
      end
   // next state: grant in IDLE, hold in EXEC until the count expires, wait for the consumer in RESP
   always_comb
      state_nxt = state == IDLE ? (accept ? EXEC : IDLE)
                : state == EXEC ? (cnt == '0 ? RESP : EXEC)
                : (rsp_ready ? IDLE : RESP);
   // ALU sees the captured op only while executing, a quiet NOP otherwise
   always_comb begin
      busy = state != IDLE;
      rsp_valid = state == RESP;
      alu_op = state == EXEC ? op : OP_NOP;
      alu_src1 = state == EXEC ? src1 : '0;
      alu_src2 = state == EXEC ? src2 : '0;
      alu_src3 = state == EXEC ? src3 : '0;
      {alu_bit_in, alu_srcAc, alu_srcCy} = state == EXEC ? flags : 3'b000;
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of the ALU arbiter against a transaction-level model
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;
   localparam int MUL_C = 4;
   localparam int DIV_C = 8;
   logic clk = 1'b0, rst = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
   opcode_e req0_op = OP_NOP, req1_op = OP_NOP;
   logic [7:0] req0_src1 = '0, req0_src2 = '0, req0_src3 = '0;
   logic [7:0] req1_src1 = '0, req1_src2 = '0, req1_src3 = '0;
   logic [2:0] req0_flags = '0, req1_flags = '0;
   logic rsp_valid, rsp_ready = 1'b1, rsp_id;
   logic [7:0] rsp_des1, rsp_des2, rsp_des_acc;
   logic [2:0] rsp_flags;
   opcode_e alu_op;
   logic [7:0] alu_src1, alu_src2, alu_src3, alu_des1, alu_des2, alu_des_acc;
   logic alu_srcCy, alu_srcAc, alu_bit_in, alu_desCy, alu_desAc, alu_desOv, busy;
   int n_checks = 0, n_fail = 0;
   logic last_ref = 1'b1;
   int hold = 0;
   logic [30:0] alu_in, prev_in = '0;
   logic [26:0] stub;

   alu_arbiter #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_src3(req0_src3), .req0_flags(req0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_src3(req1_src3), .req1_flags(req1_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_des1(rsp_des1), .rsp_des2(rsp_des2), .rsp_des_acc(rsp_des_acc), .rsp_flags(rsp_flags),
      .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_src3(alu_src3),
      .alu_srcCy(alu_srcCy), .alu_srcAc(alu_srcAc), .alu_bit_in(alu_bit_in),
      .alu_des1(alu_des1), .alu_des2(alu_des2), .alu_des_acc(alu_des_acc),
      .alu_desCy(alu_desCy), .alu_desAc(alu_desAc), .alu_desOv(alu_desOv),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // ALU result model: {des1, des2, des_acc, desOv, desAc, desCy}
   function automatic logic [26:0] alu_ref(opcode_e op, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [2:0] f);
      logic [8:0] s;
      logic [4:0] s4;
      logic [15:0] p;
      logic [7:0] acc, d2;
      logic ov, ac, cy;
      acc = a ^ b ^ c;
      d2 = {f, 5'b0} ^ b;
      ov = 1'b0;
      ac = 1'b0;
      cy = f[0];
      case (op)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b} + {8'b0, f[0]};
            s4 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, f[0]};
            acc = s[7:0]; cy = s[8]; ac = s4[4];
            ov = (a[7] == b[7]) && (acc[7] != a[7]);
         end
         OP_SUB: begin
            s = {1'b0, a} - {1'b0, b} - {8'b0, f[0]};
            s4 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, f[0]};
            acc = s[7:0]; cy = s[8]; ac = s4[4];
            ov = (a[7] != b[7]) && (acc[7] != a[7]);
         end
         OP_MUL: begin
            p = a * b;
            acc = p[7:0]; d2 = p[15:8]; ov = |p[15:8]; cy = 1'b0;
         end
         OP_DIV: begin
            cy = 1'b0;
            if (b == 8'h00) begin acc = 8'h00; d2 = 8'h00; ov = 1'b1; end
            else begin acc = a / b; d2 = a % b; end
         end
         default: ;
      endcase
      return {a ^ c, d2, acc, ov, ac, cy};
   endfunction

   function automatic int lat_of(opcode_e op);
      return op == OP_MUL ? MUL_C : op == OP_DIV ? DIV_C : 1;
   endfunction

   // multi-cycle ALU stub: MUL/DIV results are garbage until the inputs have been held long enough
   assign alu_in = {alu_op, alu_src1, alu_src2, alu_src3, alu_bit_in, alu_srcAc, alu_srcCy};
   always @(posedge clk) begin
      prev_in <= alu_in;
      hold <= alu_op == OP_NOP ? 0 : alu_in == prev_in ? hold + 1 : 1;
   end
   always_comb begin
      stub = alu_ref(alu_op, alu_src1, alu_src2, alu_src3, {alu_bit_in, alu_srcAc, alu_srcCy});
      if ((alu_op == OP_MUL && hold < MUL_C - 1) || (alu_op == OP_DIV && hold < DIV_C - 1))
         stub = {24'hEEEEEE, 3'b101};
   end
   assign {alu_des1, alu_des2, alu_des_acc, alu_desOv, alu_desAc, alu_desCy} = stub;

   task automatic set_req(input int r, input logic v, input opcode_e op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [2:0] f);
      if (r == 0) begin req0_valid = v; req0_op = op; req0_src1 = a; req0_src2 = b; req0_src3 = c; req0_flags = f; end
      else begin req1_valid = v; req1_op = op; req1_src1 = a; req1_src2 = b; req1_src3 = c; req1_flags = f; end
   endtask

   task automatic do_reset();
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; last_ref = 1'b1;
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) @(negedge clk);
   endtask

   // issue one op alone and measure: cycles waited for ready, cycles to rsp_valid, EXEC cycles, input stability
   task automatic issue(input int r, input opcode_e op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [2:0] f,
                        output int w, output int lat, output int n_exec, output bit stable);
      logic [30:0] first;
      first = '0;
      @(negedge clk);
      set_req(r, 1'b1, op, a, b, c, f);
      #1;
      w = 0;
      while (!(r == 1 ? req1_ready : req0_ready) && w < 40) begin @(negedge clk); #1; w++; end
      @(posedge clk);
      #1 set_req(r, 1'b0, op, a, b, c, f);
      lat = 0; n_exec = 0; stable = 1'b1;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (alu_op == op) begin
            if (n_exec == 0) first = alu_in;
            else if (alu_in != first) stable = 1'b0;
            n_exec++;
         end
         if (rsp_valid) lat = i;
      end
   endtask

   task automatic test_reset();
      rsp_ready = 1'b1;
      set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02, 8'h00, 3'b000);
      set_req(1, 1'b1, OP_ADD, 8'h03, 8'h04, 8'h00, 3'b000);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid, rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags} !== 30'h0) begin
         n_fail++; $display("FAIL reset_rsp: got %h required 0", {busy, rsp_valid, rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags});
      end
      n_checks++;
      if (alu_in !== {OP_NOP, 27'h0}) begin n_fail++; $display("FAIL reset_alu: got %h required %h", alu_in, {OP_NOP, 27'h0}); end
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_pointer: readys %b required 10", {req0_ready, req1_ready}); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b required 0", busy); end
   endtask

   task automatic test_add();
      int w, lat, n;
      bit st;
      rsp_ready = 1'b1;
      issue(0, OP_ADD, 8'h12, 8'h34, 8'h00, 3'b000, w, lat, n, st);
      n_checks++;
      if (w != 0) begin n_fail++; $display("FAIL add_ready: waited %0d cycles required 0", w); end
      n_checks++;
      if (n != 1) begin n_fail++; $display("FAIL add_exec_cycles: got %0d required 1", n); end
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL add_latency: got %0d required 2", lat); end
      n_checks++;
      if ({rsp_id, rsp_des_acc, rsp_flags} !== {1'b0, 8'h46, 3'b000}) begin
         n_fail++; $display("FAIL add_result: id/acc/flags %h required %h", {rsp_id, rsp_des_acc, rsp_flags}, {1'b0, 8'h46, 3'b000});
      end
      @(posedge clk);
      last_ref = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL add_release: busy/rsp_valid %b required 00", {busy, rsp_valid}); end
   endtask

   task automatic test_add_flags();
      int w, lat, n;
      bit st;
      rsp_ready = 1'b1;
      issue(0, OP_ADD, 8'hFF, 8'h01, 8'h00, 3'b000, w, lat, n, st);
      n_checks++;
      if ({rsp_des_acc, rsp_flags} !== {8'h00, 3'b011}) begin
         n_fail++; $display("FAIL add_carry: acc/flags %h required %h", {rsp_des_acc, rsp_flags}, {8'h00, 3'b011});
      end
      @(posedge clk);
      last_ref = 1'b0;
      #1 drain();
   endtask

   task automatic test_mul();
      int w, lat, n;
      bit st;
      rsp_ready = 1'b1;
      issue(1, OP_MUL, 8'h10, 8'h10, 8'h00, 3'b000, w, lat, n, st);
      n_checks++;
      if (n != MUL_C || !st) begin n_fail++; $display("FAIL mul_hold: %0d cycles stable=%0d required %0d stable=1", n, st, MUL_C); end
      n_checks++;
      if (lat != MUL_C + 1) begin n_fail++; $display("FAIL mul_latency: got %0d required %0d", lat, MUL_C + 1); end
      n_checks++;
      if ({rsp_id, rsp_des2, rsp_des_acc} !== {1'b1, 16'h0100}) begin
         n_fail++; $display("FAIL mul_product: id/product %h required %h", {rsp_id, rsp_des2, rsp_des_acc}, {1'b1, 16'h0100});
      end
      n_checks++;
      if ({rsp_des1, rsp_des2, rsp_des_acc, rsp_flags} !== alu_ref(OP_MUL, 8'h10, 8'h10, 8'h00, 3'b000)) begin
         n_fail++; $display("FAIL mul_result: got %h required %h", {rsp_des1, rsp_des2, rsp_des_acc, rsp_flags}, alu_ref(OP_MUL, 8'h10, 8'h10, 8'h00, 3'b000));
      end
      @(posedge clk);
      last_ref = 1'b1;
      #1 drain();
   endtask

   task automatic test_round_robin();
      int ids[$], at[$];
      int both;
      both = 0;
      do_reset();
      rsp_ready = 1'b1;
      set_req(0, 1'b1, OP_ADD, 8'h01, 8'h02, 8'h00, 3'b000);
      set_req(1, 1'b1, OP_SUB, 8'h09, 8'h03, 8'h00, 3'b000);
      for (int i = 0; i < 30 && ids.size() < 4; i++) begin
         #1;
         if (req0_ready && req1_ready) both++;
         if (req0_ready) begin ids.push_back(0); at.push_back(i); end
         else if (req1_ready) begin ids.push_back(1); at.push_back(i); end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_checks++;
      if (both != 0) begin n_fail++; $display("FAIL rr_both_ready: %0d cycles required 0", both); end
      for (int j = 0; j < 4; j++) begin
         n_checks++;
         if (ids.size() <= j || ids[j] != j % 2) begin n_fail++; $display("FAIL rr_order: grant %0d got %0d required %0d", j, ids.size() > j ? ids[j] : -1, j % 2); end
      end
      for (int j = 0; j < 3; j++) begin
         n_checks++;
         if (at.size() <= j + 1 || at[j + 1] - at[j] != 3) begin n_fail++; $display("FAIL rr_interval: gap %0d not 3 cycles", j); end
      end
      last_ref = 1'b1;
      drain();
   endtask

   task automatic test_stall();
      int w, lat, n, bad_v, bad_d, bad_r;
      bit st;
      logic [27:0] snap;
      bad_v = 0; bad_d = 0; bad_r = 0;
      rsp_ready = 1'b0;
      issue(0, OP_XOR, 8'h5A, 8'h0F, 8'h00, 3'b000, w, lat, n, st);
      last_ref = 1'b0;
      snap = {rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags};
      set_req(0, 1'b1, OP_ADD, 8'h11, 8'h22, 8'h00, 3'b000);
      set_req(1, 1'b1, OP_ADD, 8'h33, 8'h44, 8'h00, 3'b000);
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid !== 1'b1) bad_v++;
         if ({rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags} !== snap) bad_d++;
         if (req0_ready || req1_ready) bad_r++;
         @(negedge clk);
      end
      n_checks++;
      if (bad_v != 0) begin n_fail++; $display("FAIL stall_valid: dropped %0d cycles required 0", bad_v); end
      n_checks++;
      if (bad_d != 0) begin n_fail++; $display("FAIL stall_data: changed %0d cycles required 0", bad_d); end
      n_checks++;
      if (bad_r != 0) begin n_fail++; $display("FAIL stall_ready: asserted %0d cycles required 0", bad_r); end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL stall_regrant: readys %b required 01", {req0_ready, req1_ready}); end
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      last_ref = 1'b1;
      drain();
   endtask

   task automatic test_reset_mid_div();
      int seen;
      seen = 0;
      rsp_ready = 1'b1;
      @(negedge clk);
      set_req(0, 1'b1, OP_DIV, 8'd100, 8'd7, 8'h00, 3'b000);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (alu_op !== OP_DIV) begin n_fail++; $display("FAIL div_exec: alu_op %0d required %0d", alu_op, OP_DIV); end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00 || alu_op !== OP_NOP) begin
         n_fail++; $display("FAIL div_reset: rsp_valid/busy %b alu_op %0d required 00 and NOP", {rsp_valid, busy}, alu_op);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 15; i++) begin @(negedge clk); if (rsp_valid) seen++; end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL div_dropped: rsp_valid %0d cycles required 0", seen); end
      set_req(0, 1'b1, OP_AND, 8'hF0, 8'h3C, 8'h00, 3'b000);
      set_req(1, 1'b1, OP_OR, 8'h0F, 8'h30, 8'h00, 3'b000);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL div_pointer: readys %b required 10", {req0_ready, req1_ready}); end
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      last_ref = 1'b0;
      drain();
   endtask

   task automatic test_random();
      logic out, win, exp_valid, hs, acc, exp_id, v;
      int cyc, lat_exp;
      logic [26:0] exp_rsp;
      out = 1'b0; cyc = 0; lat_exp = 1; exp_id = 1'b0; exp_rsp = '0;
      do_reset();
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         for (int r = 0; r < 2; r++) begin
            v = r == 1 ? req1_valid : req0_valid;
            if (!v)
               set_req(r, $urandom_range(0, 2) != 0, opcode_e'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
            else if ($urandom_range(0, 15) == 0) begin
               if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            end
         end
         rsp_ready = $urandom_range(0, 3) != 0;
         #1;
         win = (req0_valid && req1_valid) ? !last_ref : req1_valid;
         if (req0_valid || req1_valid) begin
            n_checks++;
            if ({req0_ready, req1_ready} !== {!out && !win, !out && win}) begin
               n_fail++; $display("FAIL rnd_ready t=%0d: readys %b required %b", t, {req0_ready, req1_ready}, {!out && !win, !out && win});
            end
         end
         exp_valid = out && cyc >= lat_exp + 1;
         n_checks++;
         if (rsp_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid t=%0d: got %b required %b", t, rsp_valid, exp_valid); end
         if (exp_valid) begin
            n_checks++;
            if ({rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags} !== {exp_id, exp_rsp}) begin
               n_fail++; $display("FAIL rnd_rsp_data t=%0d: got %h required %h", t, {rsp_id, rsp_des1, rsp_des2, rsp_des_acc, rsp_flags}, {exp_id, exp_rsp});
            end
         end
         hs = exp_valid && rsp_ready;
         acc = !out && (req0_valid || req1_valid);
         if (acc) begin
            exp_id = win;
            exp_rsp = win ? alu_ref(req1_op, req1_src1, req1_src2, req1_src3, req1_flags)
                          : alu_ref(req0_op, req0_src1, req0_src2, req0_src3, req0_flags);
            lat_exp = lat_of(win ? req1_op : req0_op);
         end
         @(posedge clk);
         if (hs) out = 1'b0;
         if (acc) begin out = 1'b1; cyc = 1; last_ref = win; end
         else if (out) cyc++;
         #1;
         if (acc) begin if (win) req1_valid = 1'b0; else req0_valid = 1'b0; end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_add_flags();
      test_mul();
      test_round_robin();
      test_stall();
      test_reset_mid_div();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester scheduler in front of the oc8051 ALU. It accepts operations from requesters 0 and 1 over valid/ready handshakes and grants them round-robin. It captures the operands and holds them stable on the ALU inputs for the op's required latency (multi-cycle MUL/DIV), then returns the sampled ALU results on a single tagged response channel. It sits between the execute-stage requesters and the alu_if-connected ALU.

Parameters:
MUL_CYCLES, 4, cycles ALU inputs held for MUL (>=1)
DIV_CYCLES, 8, cycles ALU inputs held for DIV (>=1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
reqN_valid  in  1  (N=0,1) request valid
reqN_ready  out  1  request accepted this cycle when valid&ready
reqN_op  in  opcode_e  operation
reqN_src1/reqN_src2/reqN_src3  in  8 each  operands
reqN_flags  in  3  {bit_in, srcAc, srcCy}
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester the response belongs to
rsp_des1/rsp_des2/rsp_des_acc  out  8 each  ALU results
rsp_flags  out  3  {desOv, desAc, desCy}
alu_op  out  opcode_e  to ALU op_code
alu_src1/alu_src2/alu_src3  out  8 each  to ALU operands
alu_srcCy/alu_srcAc/alu_bit_in  out  1 each  to ALU flag inputs
alu_des1/alu_des2/alu_des_acc  in  8 each  from ALU
alu_desCy/alu_desAc/alu_desOv  in  1 each  from ALU
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (rst=0, async) forces IDLE. Reset values:
  - Captured regs, result regs and cnt are 0.
  - rsp_valid=0, rsp_id=0, rsp_* =0, busy=0.
  - alu_op=NOP, alu_src*=0, flags 0.
  - Round-robin pointer last_grant=1, so req0 wins first.
- Grant in IDLE is combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
- reqN_ready = (state==IDLE) && grant==N. Both readys are 0 in EXEC and RESP.
- On accept (valid&ready at a posedge):
  - Capture op, srcs and flags, plus id.
  - Set last_grant=id.
  - Load cnt = MUL_CYCLES-1 for MUL, DIV_CYCLES-1 for DIV, 0 for all other ops (including NOP).
  - Go to EXEC.
- EXEC:
  - alu_* driven from captured regs, held stable every EXEC cycle.
  - cnt decrements each cycle.
  - When cnt==0: sample alu_des*/flags into result regs, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and data are held constant until rsp_ready.
  - On rsp_valid&rsp_ready go to IDLE. The next grant can happen the following cycle.
- IDLE and RESP: alu_op=NOP, alu_src*=0, alu flags=0.
- Latency:
  - Accept at edge k gives rsp_valid from cycle k+1+L, where L = 1 for single-cycle ops, MUL_CYCLES for MUL, DIV_CYCLES for DIV.
  - Minimum issue interval is L+2 cycles with rsp_ready=1.
- Requester rules:
  - A requester must hold payload stable while valid && !ready.
  - Deasserting valid before being granted is legal; nothing is accepted.
- Arithmetic: the arbiter performs none. Results are the ALU's outputs unchanged.
- Reset mid-operation (EXEC or RESP): the op is dropped, no response is ever produced, and the pointer returns to the reset value.
- Unknown/illegal opcodes are treated as single-cycle.

Test Plan:
- Reset, then req0 ADD src1=0x12 src2=0x34 flags=0 -> req0_ready=1 same cycle; alu_op=ADD for exactly 1 cycle; rsp_valid 2 cycles after accept with rsp_id=0, rsp_des_acc=0x46, rsp_flags=000.
- req0 and req1 both continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; one accept every 3 cycles.
- req1 MUL src1=0x10 src2=0x10, MUL_CYCLES=4 -> alu inputs stable 4 consecutive cycles; rsp_valid 5 cycles after accept; rsp_des* equal the ALU outputs sampled in the 4th EXEC cycle (product 0x0100); rsp_id=1.
- Response stalled: rsp_ready=0 for 10 cycles with both requesters valid -> rsp_valid and data constant; both readys 0; no accept; the accept occurs the cycle after rsp_ready=1.
- rst=0 asserted in the 3rd EXEC cycle of DIV -> rsp_valid=0, alu_op=NOP, busy=0 immediately; after release, no response for the dropped op; simultaneous requests then grant req0.
- req0 ADD src1=0xFF src2=0x01 srcCy=0 -> rsp_des_acc=0x00, desCy=1, desAc=1, desOv=0.
